hazard_unit_md: RTL and testbench

Parametrised hazard/forwarding unit for the five-stage pipeline (F/D/E/M/W). It adds three things to the base design:
- Explicit write-data-valid flags replace the 32'bz "not yet computed" encoding.
- A configurable write-retention bypass register.
- A multiply/divide busy tracker that stalls HI/LO-class instructions in D while the iterative MD unit is running.

It drives PC/pipeline-register enables and flushes, and supplies forwarded operands to D, E and M.

---
 rtl/hazard_unit_md.sv | 142 ++++++++++++++
 tb/tb_hazard_unit_md.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_md.sv
// Hazard and forwarding unit for the five-stage F/D/E/M/W pipeline.
// Operands are forwarded to D, E and M using explicit result-valid flags.
// An optional retention register forwards the last nonzero W write to E.
// A busy tracker holds HI/LO-class instructions in D while the iterative
// multiply/divide unit is running.
module hazard_unit_md #(
  parameter int DW            = 32,
  parameter int AW            = 5,
  parameter int MULT_CYCLES   = 5,
  parameter int DIV_CYCLES    = 10,
  parameter int RETAIN_BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] A1D,
  input  logic [AW-1:0] A2D,
  input  logic [DW-1:0] RD1D,
  input  logic [DW-1:0] RD2D,
  input  logic          D1Use,
  input  logic          D2Use,
  input  logic          DMd,
  input  logic [AW-1:0] A1E,
  input  logic [AW-1:0] A2E,
  input  logic [DW-1:0] RD1E,
  input  logic [DW-1:0] RD2E,
  input  logic          E1Use,
  input  logic          E2Use,
  input  logic          EMdStart,
  input  logic          EMdDiv,
  input  logic [AW-1:0] A3E,
  input  logic [DW-1:0] WDE,
  input  logic          WDEValid,
  input  logic [AW-1:0] A2M,
  input  logic [DW-1:0] RD2M,
  input  logic [AW-1:0] A3M,
  input  logic [DW-1:0] WDM,
  input  logic          WDMValid,
  input  logic [AW-1:0] A3W,
  input  logic [DW-1:0] WDW,
  output logic [DW-1:0] FwdD1,
  output logic [DW-1:0] FwdD2,
  output logic [DW-1:0] FwdE1,
  output logic [DW-1:0] FwdE2,
  output logic [DW-1:0] FwdM2,
  output logic          EnPC,
  output logic          EnIFID,
  output logic          EnIDEX,
  output logic          FlushIDEX,
  output logic          FlushEXMEM,
  output logic          MdBusy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAX_CYCLES + 1) < 1) ? 1 : $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] a3r_q, a3r_d, a3r_eff;
  logic [DW-1:0] wdr_q, wdr_d;

  logic hit_1d_e, hit_1d_m, hit_2d_e, hit_2d_m;
  logic hit_1e_m, hit_1e_w, hit_1e_r, hit_2e_m, hit_2e_w, hit_2e_r;
  logic hit_2m_w;
  logic stall_d_data, stall_d_md, stall_d, stall_e, md_start;

  // A destination register of zero never produces a match
  function automatic logic hit(input logic [AW-1:0] a, input logic [AW-1:0] a3);
    return (a == a3) && (a3 != '0);
  endfunction

  // Address comparisons against every producing stage
  always_comb begin
    a3r_eff  = (RETAIN_BYPASS != 0) ? a3r_q : '0;
    hit_1d_e = hit(A1D, A3E);
    hit_1d_m = hit(A1D, A3M);
    hit_2d_e = hit(A2D, A3E);
    hit_2d_m = hit(A2D, A3M);
    hit_1e_m = hit(A1E, A3M);
    hit_1e_w = hit(A1E, A3W);
    hit_1e_r = hit(A1E, a3r_eff);
    hit_2e_m = hit(A2E, A3M);
    hit_2e_w = hit(A2E, A3W);
    hit_2e_r = hit(A2E, a3r_eff);
    hit_2m_w = hit(A2M, A3W);
  end

  // Forwarding muxes, youngest producer first
  always_comb begin
    FwdD1 = hit_1d_e ? WDE : hit_1d_m ? WDM : RD1D;
    FwdD2 = hit_2d_e ? WDE : hit_2d_m ? WDM : RD2D;
    FwdE1 = hit_1e_m ? WDM : hit_1e_w ? WDW : hit_1e_r ? wdr_q : RD1E;
    FwdE2 = hit_2e_m ? WDM : hit_2e_w ? WDW : hit_2e_r ? wdr_q : RD2E;
    FwdM2 = hit_2m_w ? WDW : RD2M;
  end

  // Stall detection; a valid E result shadows a pending M result
  always_comb begin
    stall_d_data = (D1Use && ((hit_1d_e && !WDEValid) ||
                              (hit_1d_m && !WDMValid && !(hit_1d_e && WDEValid)))) ||
                   (D2Use && ((hit_2d_e && !WDEValid) ||
                              (hit_2d_m && !WDMValid && !(hit_2d_e && WDEValid))));
    stall_e      = (E1Use && hit_1e_m && !WDMValid) || (E2Use && hit_2e_m && !WDMValid);
    md_start     = EMdStart && !stall_e;
    MdBusy       = (cnt_q != '0) || md_start;
    stall_d_md   = DMd && MdBusy;
    stall_d      = stall_d_data || stall_d_md;
    EnPC         = !(stall_d || stall_e);
    EnIFID       = !(stall_d || stall_e);
    FlushIDEX    = stall_d && !stall_e;
    EnIDEX       = !stall_e;
    FlushEXMEM   = stall_e;
  end

  // Next state for the MD busy counter and the retention register
  always_comb begin
    cnt_d = cnt_q;
    if (md_start) begin
      cnt_d = EMdDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    a3r_d = a3r_q;
    wdr_d = wdr_q;
    if ((RETAIN_BYPASS != 0) && (A3W != '0)) begin
      a3r_d = A3W;
      wdr_d = WDW;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      a3r_q <= '0;
      wdr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      a3r_q <= a3r_d;
      wdr_q <= wdr_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit_md.sv
// Scoreboard bench for hazard_unit_md: directed sequences then random traffic,
// checked against a behavioural model. A second instance without the
// retention register shares all inputs.
module tb_hazard_unit_md;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MULT_N = 5;
  localparam int DIV_N = 10;

  typedef struct packed {
    logic          reset;
    logic [AW-1:0] a1d, a2d;
    logic [DW-1:0] rd1d, rd2d;
    logic          d1use, d2use, dmd;
    logic [AW-1:0] a1e, a2e;
    logic [DW-1:0] rd1e, rd2e;
    logic          e1use, e2use, emdstart, emddiv;
    logic [AW-1:0] a3e;
    logic [DW-1:0] wde;
    logic          wdevalid;
    logic [AW-1:0] a2m;
    logic [DW-1:0] rd2m;
    logic [AW-1:0] a3m;
    logic [DW-1:0] wdm;
    logic          wdmvalid;
    logic [AW-1:0] a3w;
    logic [DW-1:0] wdw;
  } stim_t;

  typedef struct packed {
    logic [DW-1:0] fwd_d1, fwd_d2, fwd_e1, fwd_e2, fwd_m2;
    logic [DW-1:0] fwd_e1_nr, fwd_e2_nr;
    logic [5:0]    ctrl;
  } exp_t;

  logic clk = 1'b0;
  stim_t s, drv;
  exp_t sb[$];

  int checks = 0;
  int passes = 0;
  int cycle = 0;
  int busy_end = 0;
  logic [AW-1:0] ret_addr = '0;
  logic [DW-1:0] ret_data = '0;

  logic [DW-1:0] fwd_d1, fwd_d2, fwd_e1, fwd_e2, fwd_m2;
  logic en_pc, en_ifid, en_idex, flush_idex, flush_exmem, md_busy;
  logic [DW-1:0] nr_d1, nr_d2, nr_e1, nr_e2, nr_m2;
  logic nr_pc, nr_ifid, nr_idex, nr_fidex, nr_fexmem, nr_busy;

  always #5 clk = ~clk;

  initial drv = '0;

  hazard_unit_md #(.DW(DW), .AW(AW), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .RETAIN_BYPASS(1)) dut (
    .clk(clk), .reset(drv.reset),
    .A1D(drv.a1d), .A2D(drv.a2d), .RD1D(drv.rd1d), .RD2D(drv.rd2d),
    .D1Use(drv.d1use), .D2Use(drv.d2use), .DMd(drv.dmd),
    .A1E(drv.a1e), .A2E(drv.a2e), .RD1E(drv.rd1e), .RD2E(drv.rd2e),
    .E1Use(drv.e1use), .E2Use(drv.e2use), .EMdStart(drv.emdstart), .EMdDiv(drv.emddiv),
    .A3E(drv.a3e), .WDE(drv.wde), .WDEValid(drv.wdevalid),
    .A2M(drv.a2m), .RD2M(drv.rd2m), .A3M(drv.a3m), .WDM(drv.wdm), .WDMValid(drv.wdmvalid),
    .A3W(drv.a3w), .WDW(drv.wdw),
    .FwdD1(fwd_d1), .FwdD2(fwd_d2), .FwdE1(fwd_e1), .FwdE2(fwd_e2), .FwdM2(fwd_m2),
    .EnPC(en_pc), .EnIFID(en_ifid), .EnIDEX(en_idex),
    .FlushIDEX(flush_idex), .FlushEXMEM(flush_exmem), .MdBusy(md_busy)
  );

  hazard_unit_md #(.DW(DW), .AW(AW), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .RETAIN_BYPASS(0)) dut_nr (
    .clk(clk), .reset(drv.reset),
    .A1D(drv.a1d), .A2D(drv.a2d), .RD1D(drv.rd1d), .RD2D(drv.rd2d),
    .D1Use(drv.d1use), .D2Use(drv.d2use), .DMd(drv.dmd),
    .A1E(drv.a1e), .A2E(drv.a2e), .RD1E(drv.rd1e), .RD2E(drv.rd2e),
    .E1Use(drv.e1use), .E2Use(drv.e2use), .EMdStart(drv.emdstart), .EMdDiv(drv.emddiv),
    .A3E(drv.a3e), .WDE(drv.wde), .WDEValid(drv.wdevalid),
    .A2M(drv.a2m), .RD2M(drv.rd2m), .A3M(drv.a3m), .WDM(drv.wdm), .WDMValid(drv.wdmvalid),
    .A3W(drv.a3w), .WDW(drv.wdw),
    .FwdD1(nr_d1), .FwdD2(nr_d2), .FwdE1(nr_e1), .FwdE2(nr_e2), .FwdM2(nr_m2),
    .EnPC(nr_pc), .EnIFID(nr_ifid), .EnIDEX(nr_idex),
    .FlushIDEX(nr_fidex), .FlushEXMEM(nr_fexmem), .MdBusy(nr_busy)
  );

  function automatic logic match(input logic [AW-1:0] a, input logic [AW-1:0] dst);
    return (a == dst) && (dst != 0);
  endfunction

  // Operand is blocked when its nearest producer has not yet computed it
  function automatic logic d_blocked(input logic use_it, input logic [AW-1:0] a, input stim_t x);
    if (!use_it) return 1'b0;
    if (match(a, x.a3e)) return !x.wdevalid;
    if (match(a, x.a3m)) return !x.wdmvalid;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] e_value(input logic [AW-1:0] a, input logic [DW-1:0] rd,
                                            input stim_t x, input logic retain,
                                            input logic [AW-1:0] raddr, input logic [DW-1:0] rdata);
    if (match(a, x.a3m)) return x.wdm;
    if (match(a, x.a3w)) return x.wdw;
    if (retain && match(a, raddr)) return rdata;
    return rd;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs, predict the response and advance the model
  task automatic applyStimulus(input bit chk);
    exp_t e;
    logic stall_d, stall_e, start, busy;
    @(posedge clk);
    #1;
    drv = s;
    stall_e = (s.e1use && match(s.a1e, s.a3m) && !s.wdmvalid) ||
              (s.e2use && match(s.a2e, s.a3m) && !s.wdmvalid);
    start = s.emdstart && !stall_e;
    busy = (cycle < busy_end) || start;
    stall_d = d_blocked(s.d1use, s.a1d, s) || d_blocked(s.d2use, s.a2d, s) || (s.dmd && busy);
    e.fwd_d1 = match(s.a1d, s.a3e) ? s.wde : match(s.a1d, s.a3m) ? s.wdm : s.rd1d;
    e.fwd_d2 = match(s.a2d, s.a3e) ? s.wde : match(s.a2d, s.a3m) ? s.wdm : s.rd2d;
    e.fwd_e1 = e_value(s.a1e, s.rd1e, s, 1'b1, ret_addr, ret_data);
    e.fwd_e2 = e_value(s.a2e, s.rd2e, s, 1'b1, ret_addr, ret_data);
    e.fwd_e1_nr = e_value(s.a1e, s.rd1e, s, 1'b0, ret_addr, ret_data);
    e.fwd_e2_nr = e_value(s.a2e, s.rd2e, s, 1'b0, ret_addr, ret_data);
    e.fwd_m2 = match(s.a2m, s.a3w) ? s.wdw : s.rd2m;
    e.ctrl = {!(stall_d || stall_e), !stall_e, stall_d && !stall_e, stall_e, busy, 1'b0};
    if (chk) sb.push_back(e);
    if (s.reset) begin
      busy_end = cycle + 1;
      ret_addr = '0;
      ret_data = '0;
    end else begin
      if (start) busy_end = cycle + (s.emddiv ? DIV_N : MULT_N) + 1;
      if (s.a3w != 0) begin
        ret_addr = s.a3w;
        ret_data = s.wdw;
      end
    end
    cycle++;
  endtask

  // Monitor: compare every presented response against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("FwdD1", fwd_d1, e.fwd_d1);
        checkOutput("FwdD2", fwd_d2, e.fwd_d2);
        checkOutput("FwdE1", fwd_e1, e.fwd_e1);
        checkOutput("FwdE2", fwd_e2, e.fwd_e2);
        checkOutput("FwdM2", fwd_m2, e.fwd_m2);
        checkOutput("ctrl{EnPC,EnIDEX,FlushIDEX,FlushEXMEM,MdBusy}",
                    {26'd0, en_pc, en_idex, flush_idex, flush_exmem, md_busy, 1'b0}, {26'd0, e.ctrl});
        checkOutput("EnIFID", {31'd0, en_ifid}, {31'd0, e.ctrl[5]});
        checkOutput("nr_FwdE1", nr_e1, e.fwd_e1_nr);
        checkOutput("nr_FwdE2", nr_e2, e.fwd_e2_nr);
        checkOutput("nr_ctrl", {26'd0, nr_pc, nr_idex, nr_fidex, nr_fexmem, nr_busy, 1'b0}, {26'd0, e.ctrl});
      end
    end
  end

  initial begin
    s = '0;
    s.reset = 1'b1;
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    s.reset = 1'b0;

    // E result forwarded to D; then destination zero falls back to GRF
    s = '0; s.a3e = 8; s.wde = 32'h1234; s.wdevalid = 1; s.a1d = 8; s.d1use = 1; s.rd1d = 32'h5555;
    applyStimulus(1'b1);
    s.a3e = 0;
    applyStimulus(1'b1);

    // Load-use: stall with lw in E, still in M, then forward from W
    s = '0; s.a3e = 9; s.a1d = 9; s.d1use = 1; s.rd1d = 32'h77;
    applyStimulus(1'b1);
    s.a3e = 0; s.a3m = 9;
    applyStimulus(1'b1);
    s = '0; s.a3w = 9; s.wdw = 32'hBEEF; s.a1e = 9; s.e1use = 1; s.rd1e = 32'h11;
    applyStimulus(1'b1);

    // E-stage stall on an uncomputed M result
    s = '0; s.e1use = 1; s.a1e = 5; s.a3m = 5;
    applyStimulus(1'b1);

    // Divide then multiply with an MD instruction waiting in D
    s = '0; s.emdstart = 1; s.emddiv = 1; s.dmd = 1;
    applyStimulus(1'b1);
    s.emdstart = 0;
    repeat (12) applyStimulus(1'b1);
    s.emdstart = 1; s.emddiv = 0;
    applyStimulus(1'b1);
    s.emdstart = 0;
    repeat (7) applyStimulus(1'b1);

    // Retention register supplies $3 after W stops writing
    s = '0; s.a3w = 3; s.wdw = 32'hAA;
    applyStimulus(1'b1);
    s.a3w = 0; s.wdw = 32'h99; s.a1e = 3; s.e1use = 1; s.rd1e = 32'h1;
    repeat (2) applyStimulus(1'b1);

    // Reset in the middle of a multiply
    s = '0; s.emdstart = 1; s.dmd = 1;
    applyStimulus(1'b1);
    s.emdstart = 0;
    repeat (2) applyStimulus(1'b1);
    s.reset = 1;
    applyStimulus(1'b1);
    s.reset = 0;
    repeat (2) applyStimulus(1'b1);

    // Random traffic with a small address range so hits are frequent
    for (int i = 0; i < 3000; i++) begin
      s.reset    = ($urandom_range(0, 63) == 0);
      s.a1d      = AW'($urandom_range(0, 3));
      s.a2d      = AW'($urandom_range(0, 3));
      s.a1e      = AW'($urandom_range(0, 3));
      s.a2e      = AW'($urandom_range(0, 3));
      s.a2m      = AW'($urandom_range(0, 3));
      s.a3e      = AW'($urandom_range(0, 3));
      s.a3m      = AW'($urandom_range(0, 3));
      s.a3w      = AW'($urandom_range(0, 3));
      s.rd1d     = $urandom; s.rd2d = $urandom;
      s.rd1e     = $urandom; s.rd2e = $urandom;
      s.rd2m     = $urandom; s.wde = $urandom;
      s.wdm      = $urandom; s.wdw = $urandom;
      s.d1use    = 1'($urandom_range(0, 1));
      s.d2use    = 1'($urandom_range(0, 1));
      s.e1use    = 1'($urandom_range(0, 1));
      s.e2use    = 1'($urandom_range(0, 1));
      s.wdevalid = 1'($urandom_range(0, 1));
      s.wdmvalid = 1'($urandom_range(0, 1));
      s.dmd      = ($urandom_range(0, 2) == 0);
      s.emdstart = ($urandom_range(0, 15) == 0);
      s.emddiv   = 1'($urandom_range(0, 1));
      applyStimulus(1'b1);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
